ram_slot_arbiter: RTL and testbench

Shares the single system RAM between the 6502 CPU port and the CRTC/video fetch port, using the slot strobes from the timing generator. Each RAM_en pulse opens one 4-cycle access slot. V_TURN selects the nominal owner of the slot; an idle owner's slot may be lent to the other requester. The block sits between the timing generator, the CPU bus interface, the video fetch logic and the RAM macro.

---
 rtl/ram_slot_arbiter.sv | 132 +++++++++++++
 tb/tb_ram_slot_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_slot_arbiter.sv
// Slot arbiter sharing one synchronous RAM between the CPU bus port and the video fetch port.
// Each RAM_en strobe opens one four-cycle slot: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
module ram_slot_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter bit STEAL_EN = 1'b1
) (
    input  logic              PIXELCLK,
    input  logic              nRESET,
    input  logic              RAM_en,
    input  logic              V_TURN,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              grant_vid
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state;
    logic   gnt_cpu;
    logic   gnt_vid;
    logic   gnt_we;
    logic   mask_cpu;
    logic   mask_vid;

    logic   cpu_live;
    logic   vid_live;
    logic   pick_cpu;
    logic   pick_vid;

    // A port acked in the previous slot is invisible for one arbitration so a
    // registered requester has time to drop its level request.
    always_comb begin
        cpu_live = cpu_req & ~mask_cpu;
        vid_live = vid_req & ~mask_vid;
        pick_cpu = 1'b0;
        pick_vid = 1'b0;
        if (V_TURN) begin
            pick_vid = vid_live;
            pick_cpu = STEAL_EN & ~vid_live & cpu_live;
        end else begin
            pick_cpu = cpu_live;
            pick_vid = STEAL_EN & ~cpu_live & vid_live;
        end
    end

    always_ff @(posedge PIXELCLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= IDLE;
            gnt_cpu   <= 1'b0;
            gnt_vid   <= 1'b0;
            gnt_we    <= 1'b0;
            mask_cpu  <= 1'b0;
            mask_vid  <= 1'b0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            vid_rdata <= '0;
            vid_ack   <= 1'b0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            grant_vid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (RAM_en) begin
                        state    <= ISSUE;
                        mask_cpu <= 1'b0;
                        mask_vid <= 1'b0;
                        gnt_cpu  <= pick_cpu;
                        gnt_vid  <= pick_vid;
                        gnt_we   <= pick_cpu & cpu_we;
                        if (pick_cpu) begin
                            ram_cs    <= 1'b1;
                            ram_we    <= cpu_we;
                            ram_addr  <= cpu_addr;
                            ram_wdata <= cpu_wdata;
                            grant_vid <= 1'b0;
                        end else if (pick_vid) begin
                            ram_cs    <= 1'b1;
                            ram_we    <= 1'b0;
                            ram_addr  <= vid_addr;
                            ram_wdata <= '0;
                            grant_vid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state  <= WAIT;
                    ram_cs <= 1'b0;
                    ram_we <= 1'b0;
                end
                WAIT: begin
                    state <= DONE;
                    if (gnt_vid) begin
                        vid_rdata <= ram_rdata;
                        vid_ack   <= 1'b1;
                        mask_vid  <= 1'b1;
                    end
                    if (gnt_cpu) begin
                        if (!gnt_we) cpu_rdata <= ram_rdata;
                        cpu_ack  <= 1'b1;
                        mask_cpu <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    cpu_ack <= 1'b0;
                    vid_ack <= 1'b0;
                    gnt_cpu <= 1'b0;
                    gnt_vid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Directed bench for ram_slot_arbiter: a stealing instance backed by a RAM model,
// plus a strict-ownership instance fed the same inputs.
module tb_ram_slot_arbiter;

    logic        PIXELCLK = 1'b0;
    logic        nRESET;
    logic        RAM_en, V_TURN;
    logic        cpu_req, cpu_we, vid_req;
    logic [14:0] cpu_addr, vid_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  ram_rdata = '0;

    logic [7:0]  cpu_rdata, vid_rdata, ram_wdata;
    logic        cpu_ack, vid_ack, ram_cs, ram_we, grant_vid;
    logic [14:0] ram_addr;

    logic [7:0]  st_cpu_rdata, st_vid_rdata, st_ram_wdata;
    logic        st_cpu_ack, st_vid_ack, st_ram_cs, st_ram_we, st_grant_vid;
    logic [14:0] st_ram_addr;

    int checks = 0;
    int failures = 0;

    always #5 PIXELCLK = ~PIXELCLK;

    ram_slot_arbiter #(.ADDR_W(15), .DATA_W(8), .STEAL_EN(1'b1)) u_dut (
        .PIXELCLK(PIXELCLK), .nRESET(nRESET), .RAM_en(RAM_en), .V_TURN(V_TURN),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .grant_vid(grant_vid)
    );

    ram_slot_arbiter #(.ADDR_W(15), .DATA_W(8), .STEAL_EN(1'b0)) u_strict (
        .PIXELCLK(PIXELCLK), .nRESET(nRESET), .RAM_en(RAM_en), .V_TURN(V_TURN),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(st_cpu_rdata), .cpu_ack(st_cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(st_vid_rdata), .vid_ack(st_vid_ack),
        .ram_cs(st_ram_cs), .ram_we(st_ram_we), .ram_addr(st_ram_addr), .ram_wdata(st_ram_wdata),
        .ram_rdata(ram_rdata), .grant_vid(st_grant_vid)
    );

    // RAM model with one-cycle read latency and a bench-side preload port
    logic [7:0]  mem [0:32767];
    logic        pl_en = 1'b0;
    logic [14:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    always @(posedge PIXELCLK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    int cpu_ack_n = 0, vid_ack_n = 0, cs_n = 0, we_bad_n = 0, st_cpu_ack_n = 0;
    always @(negedge PIXELCLK) begin
        if (cpu_ack)            cpu_ack_n    <= cpu_ack_n + 1;
        if (vid_ack)            vid_ack_n    <= vid_ack_n + 1;
        if (ram_cs)             cs_n         <= cs_n + 1;
        if (ram_we && !ram_cs)  we_bad_n     <= we_bad_n + 1;
        if (st_cpu_ack)         st_cpu_ack_n <= st_cpu_ack_n + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic        s_cs, s_we, s_gv, s_cack, s_vack;
    logic [14:0] s_addr;
    logic [7:0]  s_wdata, s_crd, s_vrd;
    int          c0, v0, sc0, cs0;

    // One slot: strobe at N0, ISSUE observed at N1, ack observed at N3.
    task automatic slot(input logic vt);
        c0 = cpu_ack_n; v0 = vid_ack_n; sc0 = st_cpu_ack_n; cs0 = cs_n;
        @(negedge PIXELCLK); RAM_en = 1'b1; V_TURN = vt;
        @(negedge PIXELCLK); RAM_en = 1'b0;
        s_cs = ram_cs; s_we = ram_we; s_addr = ram_addr; s_wdata = ram_wdata; s_gv = grant_vid;
        @(negedge PIXELCLK);
        @(negedge PIXELCLK);
        s_cack = cpu_ack; s_vack = vid_ack; s_crd = cpu_rdata; s_vrd = vid_rdata;
        #1;
    endtask

    initial begin
        nRESET = 1'b0; RAM_en = 1'b0; V_TURN = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        pl_en = 1'b1; pl_addr = 15'h1234; pl_data = 8'hA5;
        @(negedge PIXELCLK); pl_en = 1'b0;
        #1;
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_grant_vid", grant_vid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        @(negedge PIXELCLK); nRESET = 1'b1;

        // CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
        slot(1'b0);
        chk("rd_cs", s_cs, 1);
        chk("rd_addr", s_addr, 15'h1234);
        chk("rd_we", s_we, 0);
        chk("rd_gv", s_gv, 0);
        chk("rd_ack", s_cack, 1);
        chk("rd_data", s_crd, 8'hA5);
        chk("rd_ack_cnt", 32'(cpu_ack_n - c0), 1);
        chk("rd_vack_cnt", 32'(vid_ack_n - v0), 0);
        cpu_req = 1'b0;

        // Idle slots
        begin
            int c_i, v_i, cs_i;
            c_i = cpu_ack_n; v_i = vid_ack_n; cs_i = cs_n;
            for (int i = 0; i < 8; i++) slot(i[0]);
            chk("idle_cs", 32'(cs_n - cs_i), 0);
            chk("idle_cack", 32'(cpu_ack_n - c_i), 0);
            chk("idle_vack", 32'(vid_ack_n - v_i), 0);
        end

        // Write then read, with the masked slot in between
        begin
            int w0;
            w0 = cpu_ack_n;
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0100; cpu_wdata = 8'h3C;
            slot(1'b0);
            chk("wr_cs", s_cs, 1);
            chk("wr_we", s_we, 1);
            chk("wr_addr", s_addr, 15'h0100);
            chk("wr_wdata", s_wdata, 8'h3C);
            chk("wr_ack", s_cack, 1);
            chk("wr_rdata_hold", s_crd, 8'hA5);
            cpu_we = 1'b0;
            slot(1'b0);
            chk("mask_cs", s_cs, 0);
            chk("mask_ack", 32'(cpu_ack_n - c0), 0);
            slot(1'b0);
            chk("rb_we", s_we, 0);
            chk("rb_ack", s_cack, 1);
            chk("rb_data", s_crd, 8'h3C);
            chk("wr_rd_ack_total", 32'(cpu_ack_n - w0), 2);
            cpu_req = 1'b0;
            slot(1'b0);
        end

        // Contention: both held, V_TURN alternates
        cpu_req = 1'b1; cpu_addr = 15'h0100; vid_req = 1'b1; vid_addr = 15'h1234;
        for (int i = 0; i < 4; i++) begin
            logic vt;
            vt = (i % 2 == 0);
            slot(vt);
            chk("cont_gv", s_gv, vt);
            chk("cont_vack", s_vack, vt);
            chk("cont_cack", s_cack, !vt);
            chk("cont_data", vt ? s_vrd : s_crd, vt ? 8'hA5 : 8'h3C);
            chk("cont_acks", 32'((cpu_ack_n - c0) + (vid_ack_n - v0)), 1);
        end
        slot(1'b0);
        chk("cont_mask_steal_gv", s_gv, 1);
        chk("cont_mask_steal_vack", s_vack, 1);
        slot(1'b1);
        chk("cont_mask_steal2_gv", s_gv, 0);
        chk("cont_mask_steal2_cack", s_cack, 1);
        cpu_req = 1'b0; vid_req = 1'b0;
        slot(1'b0);

        // Stealing versus strict ownership in video-owned slots
        begin
            int m0, t0;
            m0 = cpu_ack_n; t0 = st_cpu_ack_n;
            cpu_req = 1'b1; cpu_addr = 15'h1234;
            slot(1'b1);
            chk("steal_s1", s_cack, 1);
            slot(1'b1);
            chk("steal_s2_masked", s_cs, 0);
            slot(1'b1);
            chk("steal_s3", s_cack, 1);
            slot(1'b1);
            chk("steal_total", 32'(cpu_ack_n - m0), 2);
            chk("strict_total", 32'(st_cpu_ack_n - t0), 0);
            slot(1'b0);
            chk("steal_own_slot", 32'(cpu_ack_n - c0), 1);
            chk("strict_own_slot", 32'(st_cpu_ack_n - sc0), 1);
            cpu_req = 1'b0;
            slot(1'b0);
        end

        // Reset during WAIT of a video read
        vid_req = 1'b1; vid_addr = 15'h0100;
        @(negedge PIXELCLK); RAM_en = 1'b1; V_TURN = 1'b1;
        @(negedge PIXELCLK); RAM_en = 1'b0;
        chk("mr_issue_cs", ram_cs, 1);
        chk("mr_issue_gv", grant_vid, 1);
        @(negedge PIXELCLK);
        v0 = vid_ack_n;
        nRESET = 1'b0;
        #1;
        chk("mr_cs", ram_cs, 0);
        chk("mr_gv", grant_vid, 0);
        chk("mr_vack", vid_ack, 0);
        chk("mr_vrdata", vid_rdata, 0);
        chk("mr_crdata", cpu_rdata, 0);
        chk("mr_addr", ram_addr, 0);
        repeat (3) @(negedge PIXELCLK);
        chk("mr_no_ack", 32'(vid_ack_n - v0), 0);
        nRESET = 1'b1;
        slot(1'b1);
        chk("mr_reserve_gv", s_gv, 1);
        chk("mr_reserve_addr", s_addr, 15'h0100);
        chk("mr_reserve_ack", s_vack, 1);
        chk("mr_reserve_data", s_vrd, 8'h3C);
        vid_req = 1'b0;
        slot(1'b0);

        chk("we_without_cs", we_bad_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
